// File: rtl/sbus_frame_tx.sv
// S.BUS frame feeder: snapshots 16 x 11-bit channels plus flags and hands the
// 25-byte frame, one 8E2 payload word per byte, to a UART transmitter.
module sbus_frame_tx #(
  parameter int         PAYLOAD_BITS = 11,
  parameter logic [7:0] HEADER_BYTE  = 8'h0F,
  parameter logic [7:0] FOOTER_BYTE  = 8'h00
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frame_start,
  input  logic [175:0]            ch_data,
  input  logic [3:0]              flags,
  input  logic                    tx_busy,
  output logic                    tx_en,
  output logic [PAYLOAD_BITS-1:0] tx_data,
  output logic                    busy,
  output logic                    frame_done
);

  localparam logic [4:0] LAST_IDX  = 5'd24;
  localparam logic [4:0] FLAGS_IDX = 5'd23;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [4:0]              byte_idx_q;
  logic [175:0]            snap_q;
  logic [3:0]              flags_q;
  logic [PAYLOAD_BITS-1:0] word_q;

  logic                    latch;
  logic                    idx_inc;
  logic [7:0]              cur_byte;
  logic [7:0]              bit_off;
  logic [PAYLOAD_BITS-1:0] cur_word;

  // Channel byte k (1..22) starts at snapshot bit (k-1)*8.
  assign bit_off = {byte_idx_q - 5'd1, 3'b000};

  always_comb begin
    cur_byte = HEADER_BYTE;
    if (byte_idx_q == LAST_IDX)
      cur_byte = FOOTER_BYTE;
    else if (byte_idx_q == FLAGS_IDX)
      cur_byte = {4'b0000, flags_q};
    else if (byte_idx_q != 5'd0)
      cur_byte = snap_q[bit_off +: 8];
  end

  assign cur_word = {2'b11, ^cur_byte, cur_byte};

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold its value.
  always_comb begin
    state_d    = state_q;
    tx_en      = 1'b0;
    frame_done = 1'b0;
    latch      = 1'b0;
    idx_inc    = 1'b0;
    // Gating on resetn keeps a strobe off the bus during a mid-frame reset.
    if (resetn) begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) begin
            latch   = 1'b1;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (!tx_busy) begin
            tx_en   = 1'b1;
            state_d = WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (tx_busy) state_d = WAIT_DONE;
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            if (byte_idx_q == LAST_IDX) begin
              frame_done = 1'b1;
              state_d    = IDLE;
            end else begin
              idx_inc = 1'b1;
              state_d = ISSUE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      byte_idx_q <= 5'd0;
      word_q     <= '0;
    end else begin
      state_q <= state_d;
      if (latch || frame_done)
        byte_idx_q <= 5'd0;
      else if (idx_inc)
        byte_idx_q <= byte_idx_q + 5'd1;
      if (tx_en)
        word_q <= cur_word;
    end
  end

  // NOTE: the snapshot registers are deliberately left out of reset; they are
  // always loaded before being read, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    if (latch) begin
      snap_q  <= ch_data;
      flags_q <= flags;
    end
  end

  // The word is presented in the strobe cycle and held until the next issue.
  assign tx_data = tx_en ? cur_word : word_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_sbus_frame_tx.sv
// Self-checking bench for sbus_frame_tx: behavioural UART transmitter model
// plus a reference that builds each S.BUS frame directly from its byte rules.
module tb_sbus_frame_tx;

  localparam int TX_LEN = 110;

  logic         clk = 1'b0;
  logic         resetn;
  logic         frame_start;
  logic [175:0] ch_data;
  logic [3:0]   flags;
  logic         tx_busy;
  logic         tx_en;
  logic [10:0]  tx_data;
  logic         busy;
  logic         frame_done;

  sbus_frame_tx dut (
    .clk        (clk),
    .resetn     (resetn),
    .frame_start(frame_start),
    .ch_data    (ch_data),
    .flags      (flags),
    .tx_busy    (tx_busy),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    n_vec++;
    if (got_v !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
    end
  endtask

  // Transmitter model: goes busy the cycle after it latches, for TX_LEN cycles.
  logic m_busy = 1'b0;
  int   m_cnt  = 0;
  logic hold_busy = 1'b0;

  always @(posedge clk) begin
    if (tx_en) begin
      m_busy <= 1'b1;
      m_cnt  <= TX_LEN;
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_cnt  <= 0;
      m_busy <= 1'b0;
    end
  end

  assign tx_busy = m_busy | hold_busy;

  // Monitor: captures issued words and checks the handshake rules.
  logic [10:0] got[$];
  int          first_en_cyc = -1;
  int          done_cnt = 0;
  logic        armed = 1'b0;

  always @(negedge clk) begin
    if (tx_busy) armed = 1'b0;
    if (tx_en) begin
      check("en_while_busy", 32'(tx_busy), 32'd0);
      check("en_without_ack", 32'(armed), 32'd0);
      armed = 1'b1;
      if (got.size() == 0) first_en_cyc = cyc;
      got.push_back(tx_data);
    end
    if (frame_done) done_cnt++;
  end

  // Reference: byte k of the frame, encoded as an 8E2 payload word.
  function automatic logic [10:0] exp_word(input int k, input logic [175:0] ch,
                                           input logic [3:0] fl);
    logic [7:0]   b;
    logic [175:0] sh;
    if (k == 0)       b = 8'h0F;
    else if (k == 24) b = 8'h00;
    else if (k == 23) b = {4'b0000, fl};
    else begin
      sh = ch >> ((k - 1) * 8);
      b  = sh[7:0];
    end
    return {2'b11, 1'($countones(b) % 2), b};
  endfunction

  function automatic logic [175:0] rand_ch();
    logic [175:0] r = '0;
    for (int i = 0; i < 6; i++) r = {r[143:0], 32'($urandom())};
    return r;
  endfunction

  task automatic start_frame(input logic [175:0] ch, input logic [3:0] fl);
    @(posedge clk); #1;
    ch_data      = ch;
    flags        = fl;
    frame_start  = 1'b1;
    got.delete();
    first_en_cyc = -1;
    done_cnt     = 0;
    start_cyc    = cyc;
    @(posedge clk); #1;
    frame_start  = 1'b0;
  endtask

  // Returns just after the negedge on which frame_done is seen.
  task automatic check_frame(input string name, input logic [175:0] ch,
                             input logic [3:0] fl, input bit chk_lat);
    bit ok = 1'b0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
    check({name, "_done_seen"}, 32'(ok), 32'd1);
    #1;
    check({name, "_word_count"}, 32'(got.size()), 32'd25);
    for (int k = 0; k < 25 && k < got.size(); k++)
      check($sformatf("%s_word%0d", name, k), 32'(got[k]), 32'(exp_word(k, ch, fl)));
    check({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    if (chk_lat)
      check({name, "_latency"}, 32'(first_en_cyc - start_cyc), 32'd1);
  endtask

  initial begin
    logic [175:0] ch;
    logic [3:0]   fl;
    int           n;

    resetn      = 1'b0;
    frame_start = 1'b0;
    ch_data     = '0;
    flags       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_en", 32'(tx_en), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Mid-scale channels, no flags.
    ch = {16{11'h400}};
    start_frame(ch, 4'h0);
    check_frame("mid", ch, 4'h0, 1'b1);

    // Channel 0 full-scale, failsafe flag.
    ch = 176'h7FF;
    start_frame(ch, 4'b1000);
    check_frame("ch0max", ch, 4'b1000, 1'b1);
    check("ch0max_b1_const", 32'(got[1]), 32'h6FF);
    check("ch0max_b2_const", 32'(got[2]), 32'h707);
    check("ch0max_b23_const", 32'(got[23]), 32'h708);

    // Inputs changed and a second request mid-frame must not disturb it.
    ch = rand_ch();
    fl = 4'($urandom());
    start_frame(ch, fl);
    repeat (300) @(posedge clk);
    #1;
    ch_data     = ~ch;
    flags       = ~fl;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    check_frame("snapshot", ch, fl, 1'b1);

    // Request coincident with frame_done is ignored.
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (5) @(negedge clk);
    check("coincident_busy", 32'(busy), 32'd0);
    check("coincident_no_en", 32'(got.size()), 32'd25);

    // Transmitter busy when the request arrives.
    ch = rand_ch();
    fl = 4'($urandom());
    hold_busy = 1'b1;
    start_frame(ch, fl);
    repeat (20) @(negedge clk);
    check("held_no_en", 32'(got.size()), 32'd0);
    @(posedge clk); #1;
    hold_busy = 1'b0;
    check_frame("held", ch, fl, 1'b0);
    check("held_first_word", 32'(got[0]), 32'h60F);

    // Reset while byte 10 is in flight.
    ch = rand_ch();
    fl = 4'($urandom());
    start_frame(ch, fl);
    for (int i = 0; i < 3000 && got.size() < 11; i++) @(negedge clk);
    check("reach_byte10", 32'(got.size() >= 11), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_tx_en", 32'(tx_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    n = got.size();
    done_cnt = 0;
    for (int i = 0; i < 300 && tx_busy; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'd0);
    check("midrst_no_en", 32'(got.size()), 32'(n));
    ch = rand_ch();
    fl = 4'($urandom());
    start_frame(ch, fl);
    check_frame("after_rst", ch, fl, 1'b1);

    // Back-to-back random frames, each requested the cycle after frame_done.
    for (int f = 0; f < 3; f++) begin
      ch = rand_ch();
      fl = 4'($urandom());
      start_frame(ch, fl);
      check_frame($sformatf("b2b%0d", f), ch, fl, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
